mips_reg_writeback: RTL and testbench

- Write-side front end for the 32x32 MIPS register file. Drives the register file's write port: signal_reg_write, write_reg and write_data.
- Merges two writeback sources:
  - the single-cycle ALU path, which has fixed priority and never stalls;
  - the multi-cycle load/multiply path, which uses a valid/ready handshake and a small in-order FIFO.
- Exports a pending-write scoreboard so hazard logic can stall readers of registers that still have queued writes.

---
 rtl/mips_reg_writeback.sv | 121 ++++++++++++
 tb/tb_mips_reg_writeback.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/mips_reg_writeback.sv
// mips_reg_writeback: register-file write-port arbiter. The ALU path has fixed priority;
// load/multiply results queue in an in-order FIFO and are tracked by a pending-write scoreboard.
`default_nettype none

module mips_reg_writeback #(
    parameter int DEPTH = 4,
    parameter int CNT_W = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             alu_wr_en,
    input  logic [4:0]       alu_wr_reg,
    input  logic [31:0]      alu_wr_data,
    input  logic             mem_wr_valid,
    output logic             mem_wr_ready,
    input  logic [4:0]       mem_wr_reg,
    input  logic [31:0]      mem_wr_data,
    output logic             signal_reg_write,
    output logic [4:0]       write_reg,
    output logic [31:0]      write_data,
    output logic [31:0]      pending_mask,
    output logic [CNT_W-1:0] fifo_count
);

    localparam int PTR_W = CNT_W - 1;

    logic [4:0]       fifo_reg  [DEPTH];
    logic [31:0]      fifo_data [DEPTH];
    logic [DEPTH-1:0] fifo_live;
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;

    logic             alu_fire;
    logic             enq;
    logic             deq;
    logic [DEPTH-1:0] live_nxt;
    logic [31:0]      pend_nxt;

    assign mem_wr_ready = (fifo_count != CNT_W'(DEPTH));
    assign alu_fire     = alu_wr_en && (alu_wr_reg != 5'd0);
    // Transfers to $0 complete the handshake but are never stored.
    assign enq          = mem_wr_valid && mem_wr_ready && (mem_wr_reg != 5'd0);
    assign deq          = !alu_fire && (fifo_count != '0);

    always_comb begin
        live_nxt = fifo_live;
        pend_nxt = '0;
        // The ALU write is program-younger than every queued entry, so it kills matching ones;
        // an entry enqueued on this same edge is younger still and survives.
        for (int i = 0; i < DEPTH; i++) begin
            if (alu_fire && fifo_reg[i] == alu_wr_reg) begin
                live_nxt[i] = 1'b0;
            end
        end
        if (deq) begin
            live_nxt[rd_ptr] = 1'b0;
        end
        if (enq) begin
            live_nxt[wr_ptr] = 1'b1;
        end
        for (int i = 0; i < DEPTH; i++) begin
            if (live_nxt[i]) begin
                if (enq && PTR_W'(i) == wr_ptr) begin
                    pend_nxt[mem_wr_reg] = 1'b1;
                end else begin
                    pend_nxt[fifo_reg[i]] = 1'b1;
                end
            end
        end
        pend_nxt[0] = 1'b0;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                fifo_reg[i]  <= '0;
                fifo_data[i] <= '0;
            end
            fifo_live        <= '0;
            wr_ptr           <= '0;
            rd_ptr           <= '0;
            fifo_count       <= '0;
            pending_mask     <= '0;
            signal_reg_write <= 1'b0;
            write_reg        <= '0;
            write_data       <= '0;
        end else begin
            fifo_live    <= live_nxt;
            pending_mask <= pend_nxt;

            if (enq) begin
                fifo_reg[wr_ptr]  <= mem_wr_reg;
                fifo_data[wr_ptr] <= mem_wr_data;
                wr_ptr            <= wr_ptr + PTR_W'(1);
            end
            if (deq) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            case ({enq, deq})
                2'b10:   fifo_count <= fifo_count + CNT_W'(1);
                2'b01:   fifo_count <= fifo_count - CNT_W'(1);
                default: fifo_count <= fifo_count;
            endcase

            if (alu_fire) begin
                signal_reg_write <= 1'b1;
                write_reg        <= alu_wr_reg;
                write_data       <= alu_wr_data;
            end else if (deq) begin
                signal_reg_write <= fifo_live[rd_ptr];
                write_reg        <= fifo_reg[rd_ptr];
                write_data       <= fifo_data[rd_ptr];
            end else begin
                signal_reg_write <= 1'b0;
            end
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_mips_reg_writeback.sv
// tb_mips_reg_writeback: directed and randomized checks of mips_reg_writeback against a queue-based model.
`default_nettype none

module tb_mips_reg_writeback;

    localparam int DEPTH = 4;
    localparam int CNT_W = 3;

    logic             clk = 1'b0;
    logic             rst;
    logic             alu_wr_en;
    logic [4:0]       alu_wr_reg;
    logic [31:0]      alu_wr_data;
    logic             mem_wr_valid;
    logic             mem_wr_ready;
    logic [4:0]       mem_wr_reg;
    logic [31:0]      mem_wr_data;
    logic             signal_reg_write;
    logic [4:0]       write_reg;
    logic [31:0]      write_data;
    logic [31:0]      pending_mask;
    logic [CNT_W-1:0] fifo_count;

    mips_reg_writeback #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
        .clk              (clk),
        .rst              (rst),
        .alu_wr_en        (alu_wr_en),
        .alu_wr_reg       (alu_wr_reg),
        .alu_wr_data      (alu_wr_data),
        .mem_wr_valid     (mem_wr_valid),
        .mem_wr_ready     (mem_wr_ready),
        .mem_wr_reg       (mem_wr_reg),
        .mem_wr_data      (mem_wr_data),
        .signal_reg_write (signal_reg_write),
        .write_reg        (write_reg),
        .write_data       (write_data),
        .pending_mask     (pending_mask),
        .fifo_count       (fifo_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [4:0]  r;
        logic [31:0] d;
        logic        live;
    } ent_t;

    ent_t        q[$];
    logic        m_srw;
    logic [4:0]  m_reg;
    logic [31:0] m_data;
    int          checks = 0;
    int          errors = 0;
    logic        acc;
    logic        offer_v;
    logic [4:0]  offer_r;
    logic [31:0] offer_d;
    int          sent;
    int          srw_seen;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] model_pending();
        logic [31:0] m = '0;
        foreach (q[i]) if (q[i].live) m |= (32'd1 << q[i].r);
        m[0] = 1'b0;
        return m;
    endfunction

    // Called at posedge+1; drives one cycle of stimulus, advances the model and checks all outputs.
    task automatic step(input logic ae, input logic [4:0] ar, input logic [31:0] ad,
                        input logic mv, input logic [4:0] mr, input logic [31:0] md,
                        output logic accepted);
        logic rdy;
        ent_t e;
        alu_wr_en = ae; alu_wr_reg = ar; alu_wr_data = ad;
        mem_wr_valid = mv; mem_wr_reg = mr; mem_wr_data = md;
        #1;
        rdy = (q.size() != DEPTH);
        chk("ready", 32'(mem_wr_ready), 32'(rdy));
        accepted = mv && rdy;
        @(posedge clk);
        if (ae && ar != 5'd0) begin
            m_srw = 1'b1; m_reg = ar; m_data = ad;
            foreach (q[i]) if (q[i].r == ar) q[i].live = 1'b0;
        end else if (q.size() != 0) begin
            e = q.pop_front();
            m_srw = e.live; m_reg = e.r; m_data = e.d;
        end else begin
            m_srw = 1'b0;
        end
        if (accepted && mr != 5'd0) begin
            e.r = mr; e.d = md; e.live = 1'b1;
            q.push_back(e);
        end
        #1;
        chk("signal_reg_write", 32'(signal_reg_write), 32'(m_srw));
        chk("write_reg", 32'(write_reg), 32'(m_reg));
        chk("write_data", write_data, m_data);
        chk("pending_mask", pending_mask, model_pending());
        chk("fifo_count", 32'(fifo_count), q.size());
        if (signal_reg_write === 1'b1 && write_reg == 5'd0) begin
            chk("write_to_r0", 32'(write_reg), 32'd1);
        end
        if (signal_reg_write === 1'b1) srw_seen++;
    endtask

    task automatic idle();
        logic a;
        step(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, a);
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_srw"}, 32'(signal_reg_write), 32'd0);
        chk({tag, "_reg"}, 32'(write_reg), 32'd0);
        chk({tag, "_data"}, write_data, 32'd0);
        chk({tag, "_pending"}, pending_mask, 32'd0);
        chk({tag, "_count"}, 32'(fifo_count), 32'd0);
    endtask

    initial begin
        rst = 1'b1;
        alu_wr_en = 1'b0; alu_wr_reg = '0; alu_wr_data = '0;
        mem_wr_valid = 1'b0; mem_wr_reg = '0; mem_wr_data = '0;
        m_srw = 1'b0; m_reg = '0; m_data = '0;
        offer_v = 1'b0; offer_r = '0; offer_d = '0;
        srw_seen = 0;
        #12;
        chk_zero("reset");
        rst = 1'b0;
        #4;

        // ALU write, then an idle cycle
        step(1'b1, 5'd5, 32'h1234_5678, 1'b0, 5'd0, 32'd0, acc);
        chk("alu5_srw", 32'(signal_reg_write), 32'd1);
        chk("alu5_data", write_data, 32'h1234_5678);
        idle();
        chk("alu5_after", 32'(signal_reg_write), 32'd0);

        // Single load, minimum latency
        step(1'b0, 5'd0, 32'd0, 1'b1, 5'd8, 32'hDEAD_BEEF, acc);
        chk("mem8_pending", pending_mask, 32'h0000_0100);
        chk("mem8_count", 32'(fifo_count), 32'd1);
        idle();
        chk("mem8_write", write_data, 32'hDEAD_BEEF);
        chk("mem8_drained", 32'(fifo_count), 32'd0);

        // Fill under continuous ALU traffic, producer holds its offer while stalled
        sent = 0;
        for (int c = 0; c < 7; c++) begin
            step(1'b1, 5'(20 + c), 32'h100 + 32'(c), sent < 5, 5'(10 + sent), 32'h200 + 32'(sent), acc);
            if (acc) sent++;
        end
        chk("fill_accepted", sent, 4);
        chk("fill_ready", 32'(mem_wr_ready), 32'd0);
        for (int c = 0; c < 4; c++) begin
            step(1'b0, 5'd0, 32'd0, sent < 5, 5'(10 + sent), 32'h200 + 32'(sent), acc);
            if (acc) sent++;
            chk("drain_order", write_data, 32'h200 + 32'(c));
        end
        for (int c = 0; c < 2; c++) idle();
        chk("drain_ready", 32'(mem_wr_ready), 32'd1);

        // Kill a queued $9 with a younger ALU write
        step(1'b0, 5'd0, 32'd0, 1'b1, 5'd9, 32'h0000_AAAA, acc);
        step(1'b1, 5'd9, 32'h0000_BBBB, 1'b0, 5'd0, 32'd0, acc);
        chk("kill_pending", pending_mask[9], 1'b0);
        chk("kill_alu_data", write_data, 32'h0000_BBBB);
        idle();
        chk("kill_dequeue_srw", 32'(signal_reg_write), 32'd0);
        chk("kill_dequeue_count", 32'(fifo_count), 32'd0);

        // Same-edge ALU and load to $3: load is younger and survives
        step(1'b1, 5'd3, 32'h1, 1'b1, 5'd3, 32'h2, acc);
        chk("same_pending", pending_mask, 32'h0000_0008);
        idle();
        chk("same_mem_srw", 32'(signal_reg_write), 32'd1);
        chk("same_mem_data", write_data, 32'h2);
        idle();

        // Writes to $0 are dropped
        srw_seen = 0;
        step(1'b1, 5'd0, 32'h77, 1'b1, 5'd0, 32'h66, acc);
        chk("r0_accepted", 32'(acc), 32'd1);
        idle();
        chk("r0_srw_seen", srw_seen, 0);

        // Async reset with three entries queued
        for (int c = 0; c < 3; c++) step(1'b1, 5'd1, 32'(c), 1'b1, 5'(4 + c), 32'hC0 + 32'(c), acc);
        chk("pre_reset_count", 32'(fifo_count), 32'd3);
        #2 rst = 1'b1;
        #1;
        chk_zero("async_reset");
        rst = 1'b0;
        q.delete();
        m_srw = 1'b0; m_reg = '0; m_data = '0;
        #2;
        srw_seen = 0;
        for (int c = 0; c < 5; c++) idle();
        chk("post_reset_srw_seen", srw_seen, 0);

        // Randomized traffic on a small register range to exercise kills and wrap
        for (int n = 0; n < 400; n++) begin
            if (!offer_v && ($urandom % 2 == 0)) begin
                offer_v = 1'b1;
                offer_r = 5'($urandom_range(0, 7));
                offer_d = $urandom;
            end
            step(($urandom % 5) < 3, 5'($urandom_range(0, 7)), $urandom, offer_v, offer_r, offer_d, acc);
            if (acc) offer_v = 1'b0;
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
